// File: rtl/axi_pkg.sv
// Shared AXI4 types for the memory responder: burst/response encodings, FSM states, response ranking.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package axi_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    // Encoding 2'b11 is reserved and intentionally has no enum member.
    typedef enum logic [AXI_BURST_W-1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } axi_wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } axi_rstate_e;

    function automatic logic [1:0] axi_resp_rank(input axi_resp_e r);
        case (r)
            DECERR:  return 2'd2;
            SLVERR:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Worse of two response codes: DECERR > SLVERR > OKAY.
    function automatic axi_resp_e axi_resp_max(input axi_resp_e a, input axi_resp_e b);
        return (axi_resp_rank(a) >= axi_resp_rank(b)) ? a : b;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) without IDs or user sideband; master and slave modports.
// Latency: none (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    import axi_pkg::*;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [AXI_LEN_W-1:0]    awlen;
    logic [AXI_SIZE_W-1:0]   awsize;
    logic [AXI_BURST_W-1:0]  awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [AXI_RESP_W-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [AXI_LEN_W-1:0]    arlen;
    logic [AXI_SIZE_W-1:0]   arsize;
    logic [AXI_BURST_W-1:0]  arburst;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [AXI_RESP_W-1:0]   rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Next beat address for an AXI burst (FIXED/INCR, WRAP when AXI_MEM_WRAP_EN is defined); flags unsupported bursts.
// Latency: combinational.
// Backpressure: none; caller registers the result on its own handshake.
// Ports: addr/size/burst (and len with AXI_MEM_WRAP_EN) in; next_addr, burst_err out.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
`ifdef AXI_MEM_WRAP_EN
    input  logic [AXI_LEN_W-1:0]   len,
`endif
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_WIDTH-1:0]  next_addr,
    output logic                   burst_err
);

    logic [ADDR_WIDTH-1:0] step;
`ifdef AXI_MEM_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_bytes;
    logic [ADDR_WIDTH-1:0] wrap_base;
`endif

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        next_addr = addr;
        burst_err = 1'b0;
`ifdef AXI_MEM_WRAP_EN
        wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        wrap_base  = addr & ~(wrap_bytes - ADDR_WIDTH'(1));
`endif
        case (burst)
            FIXED: next_addr = addr;
            INCR:  next_addr = addr + step;
`ifdef AXI_MEM_WRAP_EN
            // Window size is a power of two only for the legal lengths,
            // so the align-down mask is valid exactly when burst_err is clear.
            WRAP: begin
                next_addr = addr + step;
                if (next_addr == wrap_base + wrap_bytes) begin
                    next_addr = wrap_base;
                end
                burst_err = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
            end
`endif
            default: burst_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a flop-array memory; independent write (AW/W/B) and read (AR/R) FSMs, one burst each.
// Latency: AW->WREADY 1 cycle, last W->BVALID 1 cycle, AR->first RVALID 1 cycle, R beats back-to-back.
// Backpressure: holds BVALID/BRESP until BREADY and RDATA/RRESP/RLAST until RREADY; AWREADY/ARREADY only when idle.
// Ports: clk, rst (sync, active-high), s (axi_if.slave). Optional feature macro: AXI_MEM_WRAP_EN (WRAP bursts).
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic  clk,
    input logic  rst,
    axi_if.slave s
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Subtract with an extra borrow bit so addresses below BASE_ADDR are rejected.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDR};
        return !d[ADDR_WIDTH] && ((d[ADDR_WIDTH-1:0] >> OFF_W) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    // ---------------- write path ----------------
    axi_wstate_e             w_state;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [AXI_LEN_W-1:0]    w_len;
    logic [AXI_SIZE_W-1:0]   w_size;
    logic [AXI_BURST_W-1:0]  w_burst;
    logic [AXI_LEN_W-1:0]    w_cnt;
    axi_resp_e               w_err;
    logic                    wready_q;
    logic                    bvalid_q;
    axi_resp_e               bresp_q;
    logic [ADDR_WIDTH-1:0]   w_next;
    logic                    w_burst_err;
    logic                    w_hs;
    logic                    w_last_beat;
    axi_resp_e               w_beat_resp;
    axi_resp_e               w_acc;
    logic                    w_we;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr      (w_addr),
`ifdef AXI_MEM_WRAP_EN
        .len       (w_len),
`endif
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next),
        .burst_err (w_burst_err)
    );

    always_comb begin
        w_hs        = s.wvalid && wready_q;
        w_last_beat = (w_cnt == w_len);
        if (w_burst_err)          w_beat_resp = SLVERR;
        else if (!in_range(w_addr)) w_beat_resp = DECERR;
        else                      w_beat_resp = OKAY;
        // A WLAST that disagrees with the beat count is an error, but the count still ends the burst.
        w_acc = axi_resp_max(w_err, w_beat_resp);
        if (s.wlast != w_last_beat) w_acc = axi_resp_max(w_acc, SLVERR);
        w_we = w_hs && (w_beat_resp == OKAY) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_err    <= OKAY;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s.awvalid) begin
                        w_addr   <= s.awaddr;
                        w_len    <= s.awlen;
                        w_size   <= s.awsize;
                        w_burst  <= s.awburst;
                        w_cnt    <= '0;
                        w_err    <= OKAY;
                        wready_q <= 1'b1;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= w_acc;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 1'b1;
                            w_addr <= w_next;
                            w_err  <= w_acc;
                        end
                    end
                end
                W_RESP: begin
                    if (s.bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s.wstrb[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= s.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s.awready = (w_state == W_IDLE) && !rst;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;

    // ---------------- read path ----------------
    axi_rstate_e             r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [AXI_LEN_W-1:0]    r_len;
    logic [AXI_SIZE_W-1:0]   r_size;
    logic [AXI_BURST_W-1:0]  r_burst;
    logic [AXI_LEN_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0]   r_next;
    logic                    r_burst_err;
    logic                    r_last;
    axi_resp_e               r_resp;
    logic [DATA_WIDTH-1:0]   r_data;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr      (r_addr),
`ifdef AXI_MEM_WRAP_EN
        .len       (r_len),
`endif
        .size      (r_size),
        .burst     (r_burst),
        .next_addr (r_next),
        .burst_err (r_burst_err)
    );

    // Read data comes straight from the array, so a same-cycle write is seen only after its edge.
    always_comb begin
        r_last = (r_state == R_DATA) && (r_cnt == r_len);
        r_resp = OKAY;
        r_data = '0;
        if (r_state == R_DATA) begin
            if (r_burst_err)            r_resp = SLVERR;
            else if (!in_range(r_addr)) r_resp = DECERR;
            if (r_resp == OKAY) r_data = mem[word_idx(r_addr)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s.arvalid) begin
                        r_addr  <= s.araddr;
                        r_len   <= s.arlen;
                        r_size  <= s.arsize;
                        r_burst <= s.arburst;
                        r_cnt   <= '0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s.rready) begin
                        if (r_last) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 1'b1;
                            r_addr <= r_next;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s.arready = (r_state == R_IDLE) && !rst;
    assign s.rvalid  = (r_state == R_DATA);
    assign s.rlast   = r_last;
    assign s.rresp   = r_resp;
    assign s.rdata   = r_data;

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

    localparam int          AW    = 32;
    localparam int          DW    = 128;
    localparam int          DEPTH = 1024;
    localparam int          BYTES = DW / 8;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [127:0] d;
        logic [1:0]   r;
        logic         l;
    } rexp_t;

    logic [127:0] mdl [0:DEPTH-1];
    logic [127:0] wd  [0:15];
    rexp_t        rq[$];
    logic [1:0]   bq[$];
    int           rbeats = 0;

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        logic [31:0] wb, base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            wb   = 32'((len + 1) << size);
            base = (start / wb) * wb;
            return base + ((start - base + 32'(i << size)) % wb);
        end
        return start + 32'(i << size);
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input int len, input logic [1:0] burst);
        if (burst == 2'b11) return 2'b10;
        if (burst == 2'b10) begin
`ifdef AXI_MEM_WRAP_EN
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
`else
            return 2'b10;
`endif
        end
        if (a < BASE || ((a - BASE) / BYTES) >= DEPTH) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int rank(input logic [1:0] r);
        return (r == 2'b11) ? 2 : (r == 2'b10) ? 1 : 0;
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (rank(a) >= rank(b)) ? a : b;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic wr(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                      input logic [15:0] strb, input int n_send, input bit bad_wlast);
        logic [1:0]  wr_resp;
        logic [1:0]  r;
        logic [31:0] a;
        int          idx;
        bit          ok;
        wr_resp = 2'b00;
        for (int i = 0; i < n_send; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            r = beat_resp(a, len, burst);
            wr_resp = worst(wr_resp, r);
            if (r == 2'b00) begin
                idx = int'((a - BASE) / BYTES);
                for (int b = 0; b < BYTES; b++)
                    if (strb[b]) mdl[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        if (bad_wlast) wr_resp = worst(wr_resp, 2'b10);
        if (n_send == len + 1) bq.push_back(wr_resp);

        bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'(size); bus.awburst = burst;
        bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.awready;
        end
        chk("aw_accept", 128'(ok), 128'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            bus.wdata = wd[i]; bus.wstrb = strb;
            bus.wlast = bad_wlast ? 1'b0 : (i == len);
            bus.wvalid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                if (i == 0 && k == 0) chk("aw_to_wready", 128'(bus.wready), 128'd1);
                ok = bus.wready;
            end
            chk("w_accept", 128'(ok), 128'd1);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        if (n_send == len + 1) begin
            @(negedge clk);
            chk("w_to_bvalid", 128'(bus.bvalid), 128'd1);
            for (int k = 0; k < 50 && bq.size() > 0; k++) @(posedge clk);
            chk("b_done", 128'(bq.size()), 128'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                      input bit stall);
        logic [31:0] a;
        rexp_t       e;
        int          start;
        bit          ok;
        bit [3:0]    pat = 4'b1001;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            e.r = beat_resp(a, len, burst);
            e.d = (e.r == 2'b00) ? mdl[int'((a - BASE) / BYTES)] : 128'd0;
            e.l = (i == len);
            rq.push_back(e);
        end
        start = rbeats;
        bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'(size); bus.arburst = burst;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.arready;
        end
        chk("ar_accept", 128'(ok), 128'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int k = 0; k < 200 && rq.size() > 0; k++) begin
            bus.rready = stall ? pat[k % 4] : 1'b1;
            if (k == 0) begin
                @(negedge clk);
                chk("ar_to_rvalid", 128'(bus.rvalid), 128'd1);
            end
            @(posedge clk); #1;
        end
        bus.rready = 1'b1;
        chk("r_drained", 128'(rq.size()), 128'd0);
        chk("r_count", 128'(rbeats - start), 128'(len + 1));
        @(posedge clk); #1;
    endtask

    // ---------------- single compare process ----------------
    initial begin
        bit r_end_prev, b_end_prev;
        r_end_prev = 1'b0;
        b_end_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                r_end_prev = 1'b0;
                b_end_prev = 1'b0;
            end else begin
                if (r_end_prev) chk("arready_after_r", 128'(bus.arready), 128'd1);
                if (b_end_prev) chk("awready_after_b", 128'(bus.awready), 128'd1);
                r_end_prev = 1'b0;
                b_end_prev = 1'b0;
                if (bus.rvalid) begin
                    if (rq.size() == 0) chk("r_unexpected", 128'(bus.rvalid), 128'd0);
                    else begin
                        chk("rdata", bus.rdata, rq[0].d);
                        chk("rresp", 128'(bus.rresp), 128'(rq[0].r));
                        chk("rlast", 128'(bus.rlast), 128'(rq[0].l));
                        if (bus.rready) begin
                            r_end_prev = rq[0].l;
                            void'(rq.pop_front());
                            rbeats++;
                        end
                    end
                end
                if (bus.bvalid) begin
                    if (bq.size() == 0) chk("b_unexpected", 128'(bus.bvalid), 128'd0);
                    else begin
                        chk("bresp", 128'(bus.bresp), 128'(bq[0]));
                        if (bus.bready) begin
                            b_end_prev = 1'b1;
                            void'(bq.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b1;
        for (int i = 0; i < 16; i++) wd[i] = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 128'(bus.awready), 128'd0);
        chk("rst_arready", 128'(bus.arready), 128'd0);
        chk("rst_wready",  128'(bus.wready),  128'd0);
        chk("rst_bvalid",  128'(bus.bvalid),  128'd0);
        chk("rst_rvalid",  128'(bus.rvalid),  128'd0);
        chk("rst_rlast",   128'(bus.rlast),   128'd0);
        chk("rst_bresp",   128'(bus.bresp),   128'd0);
        chk("rst_rresp",   128'(bus.rresp),   128'd0);
        chk("rst_rdata",   bus.rdata,         128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", 128'(bus.awready), 128'd1);
        chk("idle_arready", 128'(bus.arready), 128'd1);
        @(posedge clk); #1;

        // 4-beat INCR write then read at 0x40
        for (int i = 0; i < 4; i++) wd[i] = 128'(i + 1);
        wr(32'h40, 3, 4, 2'b01, 16'hFFFF, 4, 1'b0);
        chk("model_w0", mdl[4], 128'd1);
        chk("model_w3", mdl[7], 128'd4);
        rd(32'h40, 3, 4, 2'b01, 1'b0);

        // partial strobe over an all-F word
        wd[0] = '1;
        wr(32'h200, 0, 4, 2'b01, 16'hFFFF, 1, 1'b0);
        wd[0] = 128'h0123456789abcdef_fedcba9876543210;
        wr(32'h200, 0, 4, 2'b01, 16'h000F, 1, 1'b0);
        chk("model_strb", mdl[32], 128'hffffffff_ffffffff_ffffffff_76543210);
        rd(32'h200, 0, 4, 2'b01, 1'b0);

        // out-of-range write/read, word 0 and last word must be untouched / usable
        wd[0] = 128'h0000_aaaa;
        wr(32'h0, 0, 4, 2'b01, 16'hFFFF, 1, 1'b0);
        wd[0] = 128'h0000_3ff0;
        wr(32'h3FF0, 0, 4, 2'b01, 16'hFFFF, 1, 1'b0);
        wd[0] = 128'hdead_beef;
        chk("model_oor", 128'(beat_resp(32'h4000, 0, 2'b01)), 128'd3);
        wr(32'h4000, 0, 4, 2'b01, 16'hFFFF, 1, 1'b0);
        rd(32'h4000, 0, 4, 2'b01, 1'b0);
        rd(32'h0, 0, 4, 2'b01, 1'b0);
        rd(32'h3FF0, 0, 4, 2'b01, 1'b0);

        // WRAP LEN=3 from 0x30
        chk("model_wrap1", 128'(beat_addr(32'h30, 3, 4, 2'b10, 1)), 128'h00);
        chk("model_wrap2", 128'(beat_addr(32'h30, 3, 4, 2'b10, 2)), 128'h10);
        chk("model_wrap3", 128'(beat_addr(32'h30, 3, 4, 2'b10, 3)), 128'h20);
        for (int i = 0; i < 4; i++) wd[i] = 128'(32'h100 + i);
        wr(32'h30, 3, 4, 2'b10, 16'hFFFF, 4, 1'b0);
        rd(32'h30, 3, 4, 2'b10, 1'b0);
        rd(32'h0, 3, 4, 2'b01, 1'b0);
        rd(32'h30, 2, 4, 2'b10, 1'b0);

        // reserved burst type: error, nothing written
        for (int i = 0; i < 2; i++) wd[i] = 128'h77;
        wr(32'h40, 1, 4, 2'b11, 16'hFFFF, 2, 1'b0);
        rd(32'h40, 1, 4, 2'b11, 1'b0);
        rd(32'h40, 3, 4, 2'b01, 1'b0);

        // WLAST never asserted: SLVERR, data still written
        wd[0] = 128'h5a0; wd[1] = 128'h5a1;
        wr(32'h500, 1, 4, 2'b01, 16'hFFFF, 2, 1'b1);
        rd(32'h500, 1, 4, 2'b01, 1'b0);

        // FIXED: both beats hit the same word
        wd[0] = 128'h600; wd[1] = 128'h601;
        wr(32'h600, 1, 4, 2'b00, 16'hFFFF, 2, 1'b0);
        rd(32'h600, 1, 4, 2'b00, 1'b0);

        // 8-beat read with RREADY pattern 1,0,0,1
        for (int i = 0; i < 8; i++) wd[i] = 128'(32'h1000 + i);
        wr(32'h400, 7, 4, 2'b01, 16'hFFFF, 8, 1'b0);
        rd(32'h400, 7, 4, 2'b01, 1'b1);

        // reset during beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) wd[i] = 128'(32'h55 + i);
        wr(32'h100, 3, 4, 2'b01, 16'hFFFF, 4, 1'b0);
        for (int i = 0; i < 4; i++) wd[i] = 128'(32'ha0 + i);
        wr(32'h100, 3, 4, 2'b01, 16'hFFFF, 2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_awready", 128'(bus.awready), 128'd0);
        chk("midrst_bvalid",  128'(bus.bvalid),  128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_awready", 128'(bus.awready), 128'd1);
        chk("postrst_wready",  128'(bus.wready),  128'd0);
        chk("postrst_bvalid",  128'(bus.bvalid),  128'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("model_abort", mdl[17], 128'ha1);
        rd(32'h100, 3, 4, 2'b01, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 responder that terminates an `axi_if` slave modport with an on-chip flop-array memory, answering the read and write bursts issued by the VPU's AXI masters and the `axi_if` master tasks. The write path (AW/W/B) and read path (AR/R) are independent FSMs, each with one burst in flight. The block is the memory endpoint for unit and system benches and the local scratch memory behind the VPU fabric.

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `DATA_WIDTH`, 128: beat width in bits; power of two, at least 32.
- `MEM_DEPTH`, 1024: memory size in `DATA_WIDTH` words.
- `BASE_ADDR`, 0: byte address of word 0; must be word-aligned.

- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `s`  modport  `axi_if.slave`  full AXI slave channel set: AW*, W*, B*, AR*, R*, with widths from the interface.

## Operation
- Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8). A beat is in range iff 0 ≤ index < MEM_DEPTH.
- Beat address step: FIXED (00) = 0; INCR (01) = 2^SIZE bytes; WRAP (10) is described under Configuration; reserved (11) returns SLVERR on every beat and writes nothing.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, capture AWADDR, AWLEN, AWSIZE and AWBURST, clear the beat count, then go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB into the addressed word. An out-of-range beat writes nothing and latches DECERR.
  - The beat count sets the burst length. The burst ends on beat AWLEN. If WLAST does not match the last beat, latch SLVERR; the beat count still governs.
  - W_RESP: BVALID=1 with BRESP = worst latched code, ranked DECERR > SLVERR > OKAY. BRESP holds until BREADY, then the FSM returns to W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, capture the burst fields.
  - R_DATA: RVALID=1. RDATA is read combinationally from the current word: the full word for any SIZE, or 0 if out of range with RRESP=DECERR.
  - RLAST=1 on beat ARLEN. Each R handshake advances the address. The handshake on the RLAST beat returns the FSM to R_IDLE.
- RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0.
- A read and a write to the same word in the same cycle: the read returns the pre-write data. The write commits at the clock edge.
- Memory contents are not reset.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST = 0; BRESP, RRESP and RDATA = 0.
- Both FSMs go to idle in the cycle after `rst` is sampled high. AWREADY and ARREADY are gated low while `rst`=1.
- Reset mid-burst aborts the burst. No response is issued for the aborted burst. Beats already written remain in memory.
- AW handshake in cycle n → WREADY=1 from n+1. The last W handshake in cycle m → BVALID=1 from m+1.
- AR handshake in cycle n → first RVALID=1 in n+1. With RREADY held high, beats are back-to-back, so an (ARLEN+1)-beat burst finishes its R transfers by n+ARLEN+1.
- After B or R completes, the channel's ready (AWREADY or ARREADY) reasserts in the next cycle. Minimum spacing between bursts on a channel is therefore 1 idle cycle.
- AWLEN=0 / ARLEN=0: single beat, RLAST=1 on the first beat.

## Configuration
- `AXI_MEM_WRAP_EN` defined:
  - WRAP bursts are supported. Wrap boundary = (LEN+1)·2^SIZE bytes, aligned down from the start address.
  - The address returns to the boundary after the top byte of the wrap window.
  - A WRAP burst with LEN not in {1,3,7,15} returns SLVERR on every beat and writes nothing.
- Not defined: WRAP is treated like reserved. It gets SLVERR on every beat; writes are dropped and reads return 0.

## Structure
- Shared package `axi_pkg`:
  - burst enum `axi_burst_e` (FIXED, INCR, WRAP).
  - response enum `axi_resp_e` (OKAY=00, SLVERR=10, DECERR=11).
  - FSM state enums.
  - function `axi_resp_max`, which ranks response codes.
- Sub-module `axi_burst_addr`: combinational next-address computation from address, LEN, SIZE and BURST, including wrap. One instance serves each channel.

## Test plan
- Write 4-beat INCR at 0x40 with data 1..4 and WSTRB all ones, then read 4-beat INCR at 0x40 → RDATA 1,2,3,4 and RLAST on beat 4; BRESP and RRESP = OKAY.
- Write with WSTRB=0x000F over a word preloaded to all-F → a read returns the low 4 bytes new and the remaining bytes F.
- Read at BASE_ADDR + MEM_DEPTH·16 → RDATA=0 and RRESP=DECERR. A write to the same address → BRESP=DECERR and memory is unchanged.
- WRAP, LEN=3, start 0x30 with `AXI_MEM_WRAP_EN` → beat addresses 0x30, 0x00, 0x10, 0x20. Without the macro → SLVERR on all beats.
- RREADY toggled 1,0,0,1 during an 8-beat read → no beat lost or duplicated, and RDATA is stable while stalled.
- `rst` pulsed mid write burst (beat 2 of 4) → no BVALID, AWREADY=1 two cycles later, and beats 1–2 are retained.
